// File: rtl/addsub_pkg.sv
// Shared definitions for the serial add/subtract unit: FSM states, op encoding
// and the slice-counter width helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit slice of the add/subtract carry chain (purely combinational).
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic [CHUNK-1:0] s,
  output logic             carry_out,
  output logic             msb_carry
);

  logic [CHUNK-1:0] bx;
  logic [CHUNK:0]   sum;

  always_comb begin
    bx        = (sub == OP_SUB) ? ~b : b;
    sum       = {1'b0, a} + {1'b0, bx} + {{CHUNK{1'b0}}, carry_in};
    s         = sum[CHUNK-1:0];
    carry_out = sum[CHUNK];
    // Carry into the top bit; xor with carry_out gives signed overflow.
    msb_carry = a[CHUNK-1] ^ bx[CHUNK-1] ^ sum[CHUNK-1];
  end

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract: WIDTH bits handled CHUNK bits per clock, LSB slice
// first, with the carry held in a register between slices.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("addsub_serial: WIDTH must be a positive multiple of CHUNK");
  end

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t           state_q, state_nxt;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q, res_nxt;
  logic             cout_q, ovf_q, zero_q;

  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_out, msb_c;

  assign a_sl = a_q[cnt_q*CHUNK +: CHUNK];
  assign b_sl = b_q[cnt_q*CHUNK +: CHUNK];

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_sl),
    .b        (b_sl),
    .sub      (sub_q),
    .carry_in (carry_q),
    .s        (s_sl),
    .carry_out(c_out),
    .msb_carry(msb_c)
  );

  // Result with the current slice merged in; lets Zero see the final word.
  always_comb begin
    res_nxt = result_q;
    res_nxt[cnt_q*CHUNK +: CHUNK] = s_sl;
  end

  always_comb begin
    state_nxt = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt_q == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Operand copies need no reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q   <= A;
      b_q   <= B;
      sub_q <= sub;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_q   <= '0;
            carry_q <= (sub == OP_SUB) ? ~Cin : Cin;
          end
        end
        RUN: begin
          result_q <= res_nxt;
          carry_q  <= c_out;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cout_q <= (sub_q == OP_SUB) ? ~c_out : c_out;
            ovf_q  <= c_out ^ msb_c;
            zero_q <= (res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign Result = result_q;
  assign Cout   = cout_q;
  assign Ovf    = ovf_q;
  assign Zero   = zero_q;

endmodule
